learn_costs: RTL and testbench

// Neighbour-cost learner for the cluster-routing node. On each received frame
// (pulse on en) it searches the neighbour table held in the external byte memory
// (mem, 2048 x 8, 16-bit word port) for fsourceID. It then either updates that

---
 rtl/learn_costs.sv | 173 +++++++++++++++++
 tb/tb_learn_costs.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/learn_costs.sv
// learn_costs: neighbour-cost learner for the cluster-routing node.
// Each en pulse starts one run. The run reads the neighbour count, then scans
// the neighbour table in the external byte memory for fsourceID. A match
// refreshes that entry's battery, learned cost and cluster. Otherwise a new
// entry is appended if the table still has room. done pulses once the
// write-back is complete.
// Ports:
//   clock, nrst (async, active-high)       clock / reset
//   en                                     start pulse; inputs latched on this edge
//   fsourceID, fbatteryStat, fValue,
//   fclusterID, initial_epsilon            frame fields and link cost
//   address, wr_en, mem_data_in            memory byte address, write strobe, write data
//   mem_data_out                           combinational read data {mem[a], mem[a+1]}
//   done                                   one-cycle completion pulse
//   state_out                              current FSM state code
module learn_costs #(
  parameter int WORD_W     = 16,
  parameter int ADDR_W     = 11,
  parameter int MAX_NBR    = 32,
  parameter int TABLE_BASE = 16
) (
  input  logic              clock,
  input  logic              nrst,
  input  logic              en,
  input  logic [WORD_W-1:0] fsourceID,
  input  logic [WORD_W-1:0] fbatteryStat,
  input  logic [WORD_W-1:0] fValue,
  input  logic [WORD_W-1:0] fclusterID,
  input  logic [WORD_W-1:0] initial_epsilon,
  output logic [ADDR_W-1:0] address,
  output logic              wr_en,
  input  logic [WORD_W-1:0] mem_data_out,
  output logic [WORD_W-1:0] mem_data_in,
  output logic              done,
  output logic [4:0]        state_out
);

  typedef enum logic [4:0] {
    S_IDLE = 5'd0, S_RD_CNT = 5'd1, S_INIT = 5'd2, S_CHECK = 5'd3,
    S_RD_ID = 5'd4, S_CMP = 5'd5, S_RD_Q = 5'd6, S_CALC = 5'd7,
    S_WR_BAT = 5'd8, S_WR_Q = 5'd9, S_WR_CLU = 5'd10, S_WR_ID = 5'd11,
    S_INC_CNT = 5'd12, S_DONE = 5'd13
  } state_t;

  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(TABLE_BASE);
  localparam logic [WORD_W-1:0] MAXW = WORD_W'(MAX_NBR);

  state_t            state;
  logic [WORD_W-1:0] src, bat, val, clu, eps;
  logic [WORD_W-1:0] count, idx, id, q;
  logic              is_new;

  // Entry base address for the current index. idx never exceeds MAX_NBR, so
  // the low bits cover the whole table.
  logic [ADDR_W-1:0] ent;
  assign ent = BASE + {idx[ADDR_W-4:0], 3'b000};

  // Link cost C = sat16(fValue + epsilon).
  logic [WORD_W:0]   sum;
  logic [WORD_W-1:0] cost;
  assign sum  = {1'b0, val} + {1'b0, eps};
  assign cost = sum[WORD_W] ? '1 : sum[WORD_W-1:0];

  // Learned cost: average of the old Q (held in q) and C, using a 17-bit sum.
  logic [WORD_W:0] avg;
  assign avg = {1'b0, q} + {1'b0, cost};

  assign state_out = state;

  always_ff @(posedge clock or posedge nrst) begin
    if (nrst) begin
      state       <= S_IDLE;
      address     <= '0;
      wr_en       <= 1'b0;
      mem_data_in <= '0;
      done        <= 1'b0;
      src <= '0; bat <= '0; val <= '0; clu <= '0; eps <= '0;
      count <= '0; idx <= '0; id <= '0; q <= '0;
      is_new <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      done  <= 1'b0;
      case (state)
        S_IDLE: if (en) begin
          src <= fsourceID; bat <= fbatteryStat; val <= fValue;
          clu <= fclusterID; eps <= initial_epsilon;
          is_new  <= 1'b0;
          address <= '0;
          state   <= S_RD_CNT;
        end
        S_RD_CNT: begin
          count <= mem_data_out;
          state <= S_INIT;
        end
        S_INIT: begin
          idx   <= '0;
          state <= S_CHECK;
        end
        S_CHECK: begin
          if (idx < count && idx < MAXW) begin
            address <= ent;
            state   <= S_RD_ID;
          end else if (count < MAXW) begin
            // Scan exhausted with room left: idx == count, append there.
            is_new      <= 1'b1;
            q           <= cost;
            address     <= ent;
            mem_data_in <= src;
            wr_en       <= 1'b1;
            state       <= S_WR_ID;
          end else begin
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_RD_ID: begin
          id    <= mem_data_out;
          state <= S_CMP;
        end
        S_CMP: begin
          if (id == src) begin
            address <= ent + ADDR_W'(4);
            state   <= S_RD_Q;
          end else begin
            idx   <= idx + WORD_W'(1);
            state <= S_CHECK;
          end
        end
        S_RD_Q: begin
          q     <= mem_data_out;
          state <= S_CALC;
        end
        S_CALC, S_WR_ID: begin
          if (state == S_CALC) q <= avg[WORD_W:1];
          address     <= ent + ADDR_W'(2);
          mem_data_in <= bat;
          wr_en       <= 1'b1;
          state       <= S_WR_BAT;
        end
        S_WR_BAT: begin
          address     <= ent + ADDR_W'(4);
          mem_data_in <= q;
          wr_en       <= 1'b1;
          state       <= S_WR_Q;
        end
        S_WR_Q: begin
          address     <= ent + ADDR_W'(6);
          mem_data_in <= clu;
          wr_en       <= 1'b1;
          state       <= S_WR_CLU;
        end
        S_WR_CLU: begin
          if (is_new) begin
            address     <= '0;
            mem_data_in <= count + WORD_W'(1);
            wr_en       <= 1'b1;
            state       <= S_INC_CNT;
          end else begin
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_INC_CNT: begin
          done  <= 1'b1;
          state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_learn_costs.sv
// Bench for learn_costs: byte-memory model, a table of chained runs with
// hand-computed table contents, plus directed sequences for the preloaded
// update, a full table, en while busy and reset mid-run.
module tb_learn_costs;

  logic        clock, nrst, en;
  logic [15:0] fsourceID, fbatteryStat, fValue, fclusterID, initial_epsilon;
  logic [10:0] address;
  logic        wr_en, done;
  logic [15:0] mem_data_out, mem_data_in;
  logic [4:0]  state_out;

  learn_costs dut (
    .clock(clock), .nrst(nrst), .en(en),
    .fsourceID(fsourceID), .fbatteryStat(fbatteryStat), .fValue(fValue),
    .fclusterID(fclusterID), .initial_epsilon(initial_epsilon),
    .address(address), .wr_en(wr_en), .mem_data_out(mem_data_out),
    .mem_data_in(mem_data_in), .done(done), .state_out(state_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Byte memory. The bench preloads it through the same write port.
  logic [7:0]  mem [0:2047];
  logic        pl_we, pl_clr;
  logic [10:0] pl_addr;
  logic [15:0] pl_data;

  assign mem_data_out = {mem[address], mem[address + 11'd1]};

  always @(posedge clock) begin
    if (pl_clr) begin
      for (int i = 0; i < 2048; i++) mem[i] <= 8'h00;
    end else if (wr_en) begin
      mem[address]         <= mem_data_in[15:8];
      mem[address + 11'd1] <= mem_data_in[7:0];
    end else if (pl_we) begin
      mem[pl_addr]         <= pl_data[15:8];
      mem[pl_addr + 11'd1] <= pl_data[7:0];
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] word(input int a);
    return {mem[a], mem[a + 1]};
  endfunction

  task automatic poke(input int a, input logic [15:0] v);
    pl_addr = 11'(a); pl_data = v; pl_we = 1'b1;
    @(negedge clock);
    pl_we = 1'b0;
  endtask

  task automatic clear_mem();
    pl_clr = 1'b1;
    @(negedge clock);
    pl_clr = 1'b0;
  endtask

  // One run. gl >= 0 re-pulses en (with a different ID) at that cycle.
  task automatic run(input logic [15:0] s, b, v, c, e, input int gl,
                     output int nw, output int nd, output bit to);
    fsourceID = s; fbatteryStat = b; fValue = v; fclusterID = c; initial_epsilon = e;
    en = 1'b1;
    @(negedge clock);
    en = 1'b0; nw = 0; nd = 0; to = 1'b1;
    for (int k = 0; k < 400; k++) begin
      if (wr_en) nw++;
      if (done) nd++;
      if (state_out == 5'd0) begin to = 1'b0; break; end
      en = (k == gl);
      if (k == gl) fsourceID = 16'h0077;
      @(negedge clock);
    end
    en = 1'b0;
  endtask

  typedef struct {
    logic [15:0] src, bat, val, clu, eps;
    int          ent;
    logic [15:0] q, cnt;
    int          nwr;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int nw, nd, b;
    bit to;

    vecs[0] = '{16'd1, 16'd5, 16'd10, 16'd11, 16'd1, 0, 16'd11, 16'd1, 5};
    vecs[1] = '{16'd2, 16'd3, 16'd4, 16'd11, 16'd1, 1, 16'd5, 16'd2, 5};
    vecs[2] = '{16'd1, 16'd7, 16'd20, 16'd4, 16'd2, 0, 16'd16, 16'd2, 3};
    vecs[3] = '{16'd3, 16'd1, 16'hFFFF, 16'd2, 16'd5, 2, 16'hFFFF, 16'd3, 5};
    vecs[4] = '{16'd3, 16'd9, 16'hFFFF, 16'd5, 16'd3, 2, 16'hFFFF, 16'd3, 3};
    vecs[5] = '{16'd2, 16'd0, 16'd0, 16'd0, 16'd0, 1, 16'd2, 16'd3, 3};

    nrst = 1'b1; en = 1'b0; pl_we = 1'b0; pl_clr = 1'b1; pl_addr = '0; pl_data = '0;
    fsourceID = '0; fbatteryStat = '0; fValue = '0; fclusterID = '0; initial_epsilon = '0;
    #1;
    chk("rst_state", 32'(state_out), 32'd0);
    chk("rst_addr", 32'(address), 32'd0);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_data", 32'(mem_data_in), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    @(negedge clock);
    @(negedge clock);
    pl_clr = 1'b0;
    nrst = 1'b0;
    @(negedge clock);

    // Chained runs on a zeroed table.
    for (int i = 0; i < 6; i++) begin
      run(vecs[i].src, vecs[i].bat, vecs[i].val, vecs[i].clu, vecs[i].eps, -1, nw, nd, to);
      b = 16 + 8 * vecs[i].ent;
      chk($sformatf("v%0d_timeout", i), 32'(to), 32'd0);
      chk($sformatf("v%0d_done", i), nd, 1);
      chk($sformatf("v%0d_nwr", i), nw, vecs[i].nwr);
      chk($sformatf("v%0d_id", i), 32'(word(b)), 32'(vecs[i].src));
      chk($sformatf("v%0d_bat", i), 32'(word(b + 2)), 32'(vecs[i].bat));
      chk($sformatf("v%0d_q", i), 32'(word(b + 4)), 32'(vecs[i].q));
      chk($sformatf("v%0d_clu", i), 32'(word(b + 6)), 32'(vecs[i].clu));
      chk($sformatf("v%0d_cnt", i), 32'(word(0)), 32'(vecs[i].cnt));
    end
    chk("chain_entry3_empty", 32'(word(16 + 24)), 32'd0);

    // Update of a preloaded entry.
    clear_mem();
    poke(0, 16'd1); poke(16, 16'd31); poke(18, 16'd9); poke(20, 16'd20); poke(22, 16'd7);
    run(16'd31, 16'd5, 16'd10, 16'd11, 16'd1, -1, nw, nd, to);
    chk("upd_timeout", 32'(to), 32'd0);
    chk("upd_entry0", {word(16), word(18)}, {16'd31, 16'd5});
    chk("upd_entry0_qc", {word(20), word(22)}, {16'd15, 16'd11});
    chk("upd_cnt", 32'(word(0)), 32'd1);
    chk("upd_nwr", nw, 3);

    // Full table, no match: no writes at all.
    clear_mem();
    poke(0, 16'd32);
    for (int i = 0; i < 32; i++) poke(16 + 8 * i, 16'(100 + i));
    run(16'd5, 16'd1, 16'd1, 16'd1, 16'd1, -1, nw, nd, to);
    chk("full_timeout", 32'(to), 32'd0);
    chk("full_nwr", nw, 0);
    chk("full_done", nd, 1);
    chk("full_cnt", 32'(word(0)), 32'd32);
    chk("full_past_end", 32'(word(16 + 8 * 32)), 32'd0);

    // en re-pulsed while busy is ignored.
    clear_mem();
    run(16'h0040, 16'd1, 16'd2, 16'd3, 16'd4, 3, nw, nd, to);
    chk("busy_timeout", 32'(to), 32'd0);
    chk("busy_done", nd, 1);
    chk("busy_id", 32'(word(16)), 32'h40);
    chk("busy_q", 32'(word(20)), 32'd6);
    chk("busy_cnt", 32'(word(0)), 32'd1);
    chk("busy_no_entry1", 32'(word(24)), 32'd0);
    @(negedge clock);
    @(negedge clock);
    chk("busy_stays_idle", 32'(state_out), 32'd0);

    // Reset in WR_BAT of an append: aborts at once, ID write persists.
    fsourceID = 16'h0050; fbatteryStat = 16'd1; fValue = 16'd1;
    fclusterID = 16'd1; initial_epsilon = 16'd1;
    en = 1'b1;
    @(negedge clock);
    en = 1'b0;
    to = 1'b1;
    for (int k = 0; k < 100; k++) begin
      if (state_out == 5'd8) begin to = 1'b0; break; end
      @(negedge clock);
    end
    chk("rst_mid_reach_wr_bat", 32'(to), 32'd0);
    nrst = 1'b1;
    #1;
    chk("rst_mid_state", 32'(state_out), 32'd0);
    chk("rst_mid_wr_en", 32'(wr_en), 32'd0);
    chk("rst_mid_addr", 32'(address), 32'd0);
    @(negedge clock);
    nrst = 1'b0;
    @(negedge clock);
    chk("rst_mid_id_kept", 32'(word(24)), 32'h50);
    chk("rst_mid_bat_unwritten", 32'(word(26)), 32'd0);
    chk("rst_mid_cnt", 32'(word(0)), 32'd1);
    chk("rst_mid_idle", 32'(state_out), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
